// File: rtl/program_loader.sv
// program_loader: serial byte-stream loader that writes length-prefixed, XOR-checksummed machine code into instruction memory (ports: CLK/RST, start, rx_data/rx_valid/rx_ready, instr_mem_write_enable/MachineCodeAddress/MachineCodeData, busy/cpu_hold, done/error)
module program_loader #(
  parameter int MEM_DEPTH      = 512,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        instr_mem_write_enable,
  output logic [15:0] MachineCodeAddress,
  output logic [15:0] MachineCodeData,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);
  typedef enum logic [3:0] {IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHK, DONE, ERROR} state_t;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MAX_N = 17'(MEM_DEPTH);
  state_t state;
  logic [15:0] n, idx, len;
  logic [7:0] lo, chk;
  logic [TW-1:0] tmo;
  logic acc, timed, tmo_hit;
  assign rx_ready = state inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHK};
  assign instr_mem_write_enable = state == WRITE;
  assign busy = state inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHK};
  assign cpu_hold = busy;
  assign acc = rx_valid & rx_ready;
  assign len = {rx_data, lo};
  assign timed = state inside {LEN_HI, DATA_LO, DATA_HI, CHK};
  assign tmo_hit = tmo == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      n <= '0;
      idx <= '0;
      lo <= '0;
      chk <= '0;
      tmo <= '0;
      MachineCodeAddress <= '0;
      MachineCodeData <= '0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      if (timed) tmo <= acc ? '0 : tmo + 1'b1;
      case (state)
        IDLE, DONE, ERROR: if (start) begin
          state <= LEN_LO;
          done <= 1'b0;
          error <= 1'b0;
          idx <= '0;
          chk <= '0;
          tmo <= '0;
        end
        LEN_LO: if (acc) begin
          lo <= rx_data;
          state <= LEN_HI;
        end
        LEN_HI: if (acc) begin
          n <= len;
          error <= {1'b0, len} > MAX_N;
          state <= {1'b0, len} > MAX_N ? ERROR : len == '0 ? CHK : DATA_LO;
        end
        DATA_LO: if (acc) begin
          lo <= rx_data;
          chk <= chk ^ rx_data;
          state <= DATA_HI;
        end
        DATA_HI: if (acc) begin
          MachineCodeAddress <= idx;
          MachineCodeData <= len;
          chk <= chk ^ rx_data;
          state <= WRITE;
        end
        WRITE: begin
          idx <= idx + 16'd1;
          state <= idx + 16'd1 == n ? CHK : DATA_LO;
        end
        CHK: if (acc) begin
          done <= rx_data == chk;
          error <= rx_data != chk;
          state <= rx_data == chk ? DONE : ERROR;
        end
        default: state <= IDLE;
      endcase
      // a stalled stream overrides whatever the state decoded above
      if (timed && !acc && tmo_hit) begin
        state <= ERROR;
        error <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader
module tb_program_loader;
  logic CLK = 1'b0, RST = 1'b1, start = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_ready, we, busy, cpu_hold, done, error;
  logic [15:0] addr, data;
  int checks = 0, failures = 0, writes = 0, w0;
  program_loader #(.MEM_DEPTH(512), .TIMEOUT_CYCLES(10)) dut (
    .CLK(CLK), .RST(RST), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .instr_mem_write_enable(we), .MachineCodeAddress(addr),
    .MachineCodeData(data), .busy(busy), .cpu_hold(cpu_hold), .done(done), .error(error)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) if (we) writes++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    int k;
    k = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && k < 20) begin
      tick();
      k++;
    end
    if (!rx_ready) check("rx_ready_wait", 32'(rx_ready), 1);
    tick();
    rx_valid = 1'b0;
  endtask
  task automatic send_word(input logic [7:0] l, input logic [7:0] h, input logic [15:0] a);
    send(l);
    send(h);
    check("write_strobe", 32'(we), 1);
    check("write_addr", 32'(addr), 32'(a));
    check("write_data", 32'(data), {16'h0, h, l});
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 0);
    check({tag, "_we"}, 32'(we), 0);
    check({tag, "_addr"}, 32'(addr), 0);
    check({tag, "_data"}, 32'(data), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_hold"}, 32'(cpu_hold), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_error"}, 32'(error), 0);
  endtask
  task automatic nominal(input string tag);
    pulse_start();
    send(8'h02);
    send(8'h00);
    send_word(8'h34, 8'h12, 16'd0);
    tick();
    check({tag, "_we_low"}, 32'(we), 0);
    check({tag, "_data_hold"}, 32'(data), 32'h1234);
    send_word(8'h78, 8'h56, 16'd1);
    send(8'h08);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_error"}, 32'(error), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_hold"}, 32'(cpu_hold), 0);
    check({tag, "_rx_ready"}, 32'(rx_ready), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    repeat (2) tick();
    check_reset("reset");
    RST = 1'b0;
    tick();
    nominal("nominal");
    w0 = writes;
    pulse_start();
    check("zero_done_cleared", 32'(done), 0);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    check("zero_done", 32'(done), 1);
    check("zero_no_write", 32'(writes - w0), 0);
    pulse_start();
    send(8'h01);
    send(8'h00);
    send_word(8'hAA, 8'h55, 16'd0);
    send(8'h00);
    check("badchk_error", 32'(error), 1);
    check("badchk_done", 32'(done), 0);
    w0 = writes;
    pulse_start();
    check("oversize_error_cleared", 32'(error), 0);
    send(8'h01);
    send(8'h02);
    check("oversize_error", 32'(error), 1);
    check("oversize_busy", 32'(busy), 0);
    check("oversize_rx_ready", 32'(rx_ready), 0);
    check("oversize_no_write", 32'(writes - w0), 0);
    pulse_start();
    send(8'h01);
    repeat (9) tick();
    check("timeout_early_error", 32'(error), 0);
    check("timeout_early_busy", 32'(busy), 1);
    tick();
    check("timeout_error", 32'(error), 1);
    check("timeout_busy", 32'(busy), 0);
    pulse_start();
    check("restart_error_cleared", 32'(error), 0);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    check("restart_done", 32'(done), 1);
    w0 = writes;
    pulse_start();
    send(8'h01);
    send(8'h00);
    send(8'hAA);
    rx_data = 8'h55;
    rx_valid = 1'b1;
    RST = 1'b1;
    tick();
    rx_valid = 1'b0;
    check_reset("midreset");
    check("midreset_no_write", 32'(writes - w0), 0);
    RST = 1'b0;
    tick();
    nominal("after_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
